mult_seq16: RTL
===============

Name: mult_seq16

Overview:
- Sequential 16x16 shift-add multiplier for the execute stage.
- Drives the team's existing cla16 adder once per cycle as its only arithmetic datapath, and consumes the adder's sum and carry-out.
- Returns a 32-bit product (hi/lo) with an overflow flag under a start/done handshake.
- Selectable signed (two's complement) or unsigned operation; fixed latency, so the pipeline can stall deterministically.

Parameters:
- WIDTH, 16: operand width. Fixed at 16 to match cla16; other values are unsupported.
- ITERS, 16: number of shift-add iterations (equals WIDTH).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request a multiply; sampled only when not busy.
- a  input  16  multiplicand.
- b  input  16  multiplier.
- sign  input  1  1 = signed operands, 0 = unsigned; sampled with start.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when the result becomes valid.
- prod_lo  output  16  product bits [15:0].
- prod_hi  output  16  product bits [31:16].
- ovf  output  1  the product does not fit in 16 bits of the selected signedness.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state = IDLE.
  - busy, done, ovf, prod_lo, prod_hi = 0.
  - All internal registers cleared.
  - No partial result is ever visible after reset.
- States: IDLE, RUN, FIX_LO, FIX_HI, DONE.
- busy = 1 in RUN, FIX_LO and FIX_HI only. done = 1 in DONE only.
- IDLE or DONE with start = 1 (edge E0):
  - Latch mcand = |a| and mq = |b|; magnitude is taken only if sign = 1 and the msb is set, otherwise the raw value.
  - 0x8000 magnitude = 0x8000, treated as unsigned.
  - Latch neg = sign & (a[15] ^ b[15]) and sgn_q = sign.
  - Clear acc (17 bits), load count = 0, go to RUN.
- start while busy is ignored; no queuing.
- DONE without start: go to IDLE. The result outputs hold until the next accepted start.
- RUN (edges E1..E16), each edge:
  - cla16 inputs: a = acc[15:0], b = (mq[0] ? mcand : 0), cin = 0, sign = 0.
  - {acc, mq} <= {cout, sum, mq} >> 1.
  - count++. After the edge where count reaches ITERS-1, go to FIX_LO.
- FIX_LO (E17):
  - If neg: lo <= ~mq + 1 via cla16 (a = ~mq, b = 0, cin = 1); register its cout as cfix.
  - Else: lo <= mq and cfix = 0.
  - Go to FIX_HI.
- FIX_HI (E18):
  - If neg: hi <= ~acc[15:0] + cfix via cla16.
  - Else: hi <= acc[15:0].
  - Compute ovf; load prod_hi and prod_lo; go to DONE.
- Negation always occupies both FIX states, so latency is constant.
- Latency: start sampled at E0; done is high in the cycle after E18 (19 clock edges after acceptance). Back-to-back accept from DONE is allowed.
- ovf:
  - Unsigned: ovf = (hi != 0).
  - Signed: ovf = (hi != {16{lo[15]}}).
  - Zero product: never negative, never overflow (negating 0 yields 0 with cfix = 1, so hi = 0).
- cla16 ofl output is unused; cla16 sign input is tied to 0.
- Single shared cla16 instance; its input mux is selected by state.

Decomposition:
- Shared package mult_pkg: state enum (IDLE, RUN, FIX_LO, FIX_HI, DONE), WIDTH, ITERS, and counter width localparam (5 bits).
- Sub-module: the existing cla16 adder, instantiated once. No new sub-module.
- Magnitude conversion at E0 uses a plain two's-complement negate on the input side.

Test Plan:
- Unsigned a=3, b=5, sign=0 -> done at edge 19 after start; prod_hi=0x0000, prod_lo=0x000F, ovf=0; busy high for exactly 18 cycles.
- Unsigned a=0xFFFF, b=0xFFFF -> prod_hi=0xFFFE, prod_lo=0x0001, ovf=1.
- Signed a=0xFFFD (-3), b=0x0005 -> prod_hi=0xFFFF, prod_lo=0xFFF1, ovf=0. Signed a=0xFFFF, b=0xFFFF -> 0x0000_0001, ovf=0.
- Signed a=0x8000, b=0x8000 -> prod_hi=0x4000, prod_lo=0x0000, ovf=1. Signed a=0, b=0x8000 -> 0x0000_0000, ovf=0.
- start pulsed at cycle 5 of a running multiply with different operands -> ignored; first result unchanged. New start in the DONE cycle -> accepted; second done 19 edges later.
- rst asserted asynchronously (between edges) at iteration 8 -> busy, done, prod_hi, prod_lo, ovf = 0 immediately. Next start after reset -> correct result with normal latency.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 16x16 shift-add multiplier.
package mult_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned ITERS = WIDTH;
  localparam int unsigned CntW  = 5;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StFixLo,
    StFixHi,
    StDone
  } mult_state_e;

  // Two's-complement magnitude; 0x8000 maps to itself and is read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/cla16.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a lookahead carry across groups.
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  input  logic        sign,
  output logic [15:0] sum,
  output logic        cout,
  output logic        ofl
);

  logic [15:0] g, p;
  logic [16:0] c;
  logic [3:0]  gg, gp;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = 1'b0;
      gp[k] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        gg[k] = g[4*k+i] | (p[4*k+i] & gg[k]);
        gp[k] = gp[k] & p[4*k+i];
      end
    end
    c[0] = cin;
    for (int k = 0; k < 4; k++) begin
      for (int i = 1; i < 4; i++) begin
        c[4*k+i] = g[4*k+i-1] | (p[4*k+i-1] & c[4*k+i-1]);
      end
      c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
    end
    sum  = p ^ c[15:0];
    cout = c[16];
    // Signed overflow is carry into msb differing from carry out.
    ofl  = sign ? (c[16] ^ c[15]) : c[16];
  end

endmodule

// File: rtl/mult_seq16.sv
// Sequential 16x16 shift-add multiplier with fixed 19-edge latency, signed or unsigned,
// using one shared cla16 for both the accumulate and the sign-fix negation.
module mult_seq16
  import mult_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi,
  output logic             ovf
);

  localparam logic [CntW-1:0] LastCnt = CntW'(ITERS - 1);

  mult_state_e      state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mq_q, lo_q;
  logic [WIDTH:0]   acc_q;
  logic [CntW-1:0]  count_q;
  logic             neg_q, sgn_q, cfix_q;
  logic [WIDTH-1:0] prod_lo_q, prod_hi_q;
  logic             ovf_q;

  logic [WIDTH-1:0] add_a, add_b, add_sum, hi_d;
  logic             add_cin, add_cout, ovf_d;
  logic             unused_ofl, unused_acc_msb;

  cla16 u_cla16 (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sign (1'b0),
    .sum  (add_sum),
    .cout (add_cout),
    .ofl  (unused_ofl)
  );

  // acc[16] is always zero after a shift; kept for the 17-bit accumulator shape.
  assign unused_acc_msb = acc_q[WIDTH];

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    unique case (state_q)
      StRun: begin
        add_a = acc_q[WIDTH-1:0];
        add_b = mq_q[0] ? mcand_q : '0;
      end
      StFixLo: begin
        add_a   = ~mq_q;
        add_cin = 1'b1;
      end
      StFixHi: begin
        add_a   = ~acc_q[WIDTH-1:0];
        add_cin = cfix_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    hi_d  = neg_q ? add_sum : acc_q[WIDTH-1:0];
    ovf_d = sgn_q ? (hi_d != {WIDTH{lo_q[WIDTH-1]}}) : (hi_d != '0);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (count_q == LastCnt) state_d = StFixLo;
      StFixLo: state_d = StFixHi;
      StFixHi: state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      mq_q      <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      sgn_q     <= 1'b0;
      cfix_q    <= 1'b0;
      prod_lo_q <= '0;
      prod_hi_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            mcand_q <= magnitude(a, sign);
            mq_q    <= magnitude(b, sign);
            neg_q   <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            sgn_q   <= sign;
            acc_q   <= '0;
            count_q <= '0;
          end
        end
        StRun: begin
          acc_q   <= {1'b0, add_cout, add_sum[WIDTH-1:1]};
          mq_q    <= {add_sum[0], mq_q[WIDTH-1:1]};
          count_q <= count_q + 1'b1;
        end
        StFixLo: begin
          lo_q   <= neg_q ? add_sum : mq_q;
          cfix_q <= neg_q & add_cout;
        end
        StFixHi: begin
          prod_hi_q <= hi_d;
          prod_lo_q <= lo_q;
          ovf_q     <= ovf_d;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_q == StRun) || (state_q == StFixLo) || (state_q == StFixHi);
  assign done    = (state_q == StDone);
  assign prod_lo = prod_lo_q;
  assign prod_hi = prod_hi_q;
  assign ovf     = ovf_q;

endmodule
